// File: rtl/decoder_pkg.sv
// Shared field-layout helpers and mode encodings for the instruction decode stage.
// Field positions are derived from the instruction, opcode and register-address widths.
package decoder_pkg;

  localparam logic MODE_REG = 1'b0;
  localparam logic MODE_MEM = 1'b1;

  function automatic int imm_width(input int instr_w, input int opc_w, input int reg_aw);
    return instr_w - opc_w - 3 * reg_aw - 1;
  endfunction

  function automatic int rd_lsb(input int instr_w, input int opc_w, input int reg_aw);
    return instr_w - opc_w - reg_aw;
  endfunction

  function automatic int rs1_lsb(input int instr_w, input int opc_w, input int reg_aw);
    return instr_w - opc_w - 2 * reg_aw;
  endfunction

  function automatic int rs2_lsb(input int instr_w, input int opc_w, input int reg_aw);
    return instr_w - opc_w - 3 * reg_aw;
  endfunction

  // Replicates bit width-1 of val into every higher bit position.
  function automatic logic [63:0] sign_extend(input logic [63:0] val, input int width);
    logic [63:0] res;
    res = val;
    for (int i = 0; i < 64; i++) begin
      if (i >= width) res[i] = val[width-1];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write tracker with three busy queries.
// Busy reflects this cycle's writeback clear; a same-cycle set and clear leaves the bit set.
module reg_scoreboard
  import decoder_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [REG_AW-1:0]      set_addr,
  input  logic                   clr_en,
  input  logic [REG_AW-1:0]      clr_addr,
  input  logic [REG_AW-1:0]      q1_addr,
  input  logic [REG_AW-1:0]      q2_addr,
  input  logic [REG_AW-1:0]      q3_addr,
  output logic [2**REG_AW-1:0]   pending,
  output logic                   q1_busy,
  output logic                   q2_busy,
  output logic                   q3_busy
);
  localparam int NUM_REGS = 2 ** REG_AW;
  localparam bit ZR       = (ZERO_REG_EN != 0);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] clr_mask, set_mask, after_clr;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
    if (set_en) set_mask[set_addr] = 1'b1;
    after_clr = pending_q & ~clr_mask;
    pending_d = after_clr | set_mask;
    if (ZR) begin
      after_clr[0] = 1'b0;
      pending_d[0] = 1'b0;
    end
  end

  assign q1_busy = after_clr[q1_addr];
  assign q2_busy = after_clr[q2_addr];
  assign q3_busy = after_clr[q3_addr];
  assign pending = pending_q;

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

endmodule

// File: rtl/pipelined_instruction_decoder.sv
// Decode stage: splits an instruction into fields, holds one bundle, stalls fetch on RAW/WAW hazards.
// Latency 1 cycle; bundle held while out_ready is low, in_ready drops on hazard, flush or full output.
module pipelined_instruction_decoder
  import decoder_pkg::*;
#(
  parameter int INSTR_W     = 24,
  parameter int OPC_W       = 4,
  parameter int REG_AW      = 4,
  parameter int DATA_W      = 16,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    instruction,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OPC_W-1:0]      op_select,
  output logic [REG_AW-1:0]     reg_write_addr,
  output logic [REG_AW-1:0]     reg_read_addr1,
  output logic [REG_AW-1:0]     reg_read_addr2,
  output logic [DATA_W-1:0]     imm,
  output logic                  mem_write,
  output logic                  reg_write_enable,
  input  logic                  wb_valid,
  input  logic [REG_AW-1:0]     wb_addr,
  output logic                  stall,
  output logic [2**REG_AW-1:0]  pending,
  output logic [15:0]           stall_count
);
  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int IMM_W    = imm_width(INSTR_W, OPC_W, REG_AW);
  localparam int RD_LSB   = rd_lsb(INSTR_W, OPC_W, REG_AW);
  localparam int RS1_LSB  = rs1_lsb(INSTR_W, OPC_W, REG_AW);
  localparam int RS2_LSB  = rs2_lsb(INSTR_W, OPC_W, REG_AW);
  localparam bit ZR       = (ZERO_REG_EN != 0);

  if (IMM_W < 1 || IMM_W > DATA_W) begin : g_bad_imm_w
    $error("pipelined_instruction_decoder: immediate width %0d out of range 1..%0d", IMM_W, DATA_W);
  end

  logic [OPC_W-1:0]  opc_f;
  logic [REG_AW-1:0] rd_f, rs1_f, rs2_f;
  logic [IMM_W-1:0]  imm_f;
  logic              mode_f;

  assign opc_f  = instruction[INSTR_W-1 -: OPC_W];
  assign rd_f   = instruction[RD_LSB +: REG_AW];
  assign rs1_f  = instruction[RS1_LSB +: REG_AW];
  assign rs2_f  = instruction[RS2_LSB +: REG_AW];
  assign imm_f  = instruction[1 +: IMM_W];
  assign mode_f = instruction[0];

  logic              out_valid_q, out_valid_d;
  logic [OPC_W-1:0]  op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              mem_q, mem_d, rwe_q, rwe_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic sb_busy1, sb_busy2, sb_busy3;
  logic held_hit1, held_hit2, held_hit3;
  logic hazard, accept, issue;

  reg_scoreboard #(
    .REG_AW      (REG_AW),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue && rwe_q),
    .set_addr (rd_q),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .q1_addr  (rs1_f),
    .q2_addr  (rs2_f),
    .q3_addr  (rd_f),
    .pending  (pending),
    .q1_busy  (sb_busy1),
    .q2_busy  (sb_busy2),
    .q3_busy  (sb_busy3)
  );

  // The held bundle has not reached the scoreboard yet, so its rd is checked directly.
  assign held_hit1 = out_valid_q && rwe_q && (rd_q == rs1_f);
  assign held_hit2 = out_valid_q && rwe_q && (rd_q == rs2_f);
  assign held_hit3 = out_valid_q && rwe_q && (rd_q == rd_f);

  assign hazard   = sb_busy1 || sb_busy2 || sb_busy3 || held_hit1 || held_hit2 || held_hit3;
  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign issue    = out_valid_q && out_ready && !flush;
  assign stall    = in_valid && hazard && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    mem_d       = mem_q;
    rwe_d       = rwe_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      op_d        = opc_f;
      rd_d        = rd_f;
      rs1_d       = rs1_f;
      rs2_d       = rs2_f;
      imm_d       = DATA_W'(sign_extend(64'(imm_f), IMM_W));
      mem_d       = (mode_f == MODE_MEM);
      rwe_d       = (mode_f == MODE_REG) && !(ZR && rd_f == '0);
    end else if (issue) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      mem_q       <= 1'b0;
      rwe_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      mem_q       <= mem_d;
      rwe_q       <= rwe_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign op_select        = op_q;
  assign reg_write_addr   = rd_q;
  assign reg_read_addr1   = rs1_q;
  assign reg_read_addr2   = rs2_q;
  assign imm              = imm_q;
  assign mem_write        = mem_q;
  assign reg_write_enable = rwe_q;
  assign stall_count      = stall_cnt_q;

endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
// Randomised and directed bench for the decode stage, checked against a queue-based reference model.
module tb_pipelined_instruction_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        wb_valid = 1'b0;
  logic [23:0] instruction = '0;
  logic [3:0]  wb_addr = '0;

  logic        in_ready, out_valid, mem_write, reg_write_enable, stall;
  logic [3:0]  op_select, reg_write_addr, reg_read_addr1, reg_read_addr2;
  logic [15:0] imm, pending, stall_count;

  pipelined_instruction_decoder dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .instruction      (instruction),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .op_select        (op_select),
    .reg_write_addr   (reg_write_addr),
    .reg_read_addr1   (reg_read_addr1),
    .reg_read_addr2   (reg_read_addr2),
    .imm              (imm),
    .mem_write        (mem_write),
    .reg_write_enable (reg_write_enable),
    .wb_valid         (wb_valid),
    .wb_addr          (wb_addr),
    .stall            (stall),
    .pending          (pending),
    .stall_count      (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op, rd, rs1, rs2, imm;
    bit mem, rwe;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit [15:0] mdl_pend;
  int   mdl_cnt;
  bit   held_now, issue_now, drop_now;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [23:0] mk(input int op, input int rd, input int rs1, input int rs2,
                                     input int immv, input int mode);
    return 24'((op << 20) | (rd << 16) | (rs1 << 12) | (rs2 << 8) | ((immv % 128) << 1) | mode);
  endfunction

  function automatic exp_t decode(input logic [23:0] w);
    exp_t e;
    int v, imm7;
    v     = int'(w);
    e.op  = v >> 20;
    e.rd  = (v >> 16) % 16;
    e.rs1 = (v >> 12) % 16;
    e.rs2 = (v >> 8) % 16;
    imm7  = (v >> 1) % 128;
    e.imm = (imm7 >= 64) ? imm7 - 128 + 65536 : imm7;
    e.mem = (v % 2) == 1;
    e.rwe = (v % 2) == 0 && e.rd != 0;
    return e;
  endfunction

  // Reference model: hazard, handshake and counter expectations for this cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mdl_pend  = '0;
      mdl_cnt   = 0;
      held_now  = 0;
      issue_now = 0;
      drop_now  = 0;
    end else begin
      int  regs[3];
      bit  hz, exp_rdy, exp_stall;
      exp_t cur;
      chk("pending", 32'(pending), 32'(mdl_pend));
      chk("stall_count", 32'(stall_count), 32'(mdl_cnt));
      if (wb_valid) mdl_pend[wb_addr] = 1'b0;
      held_now = exp_q.size() > 0;
      cur      = decode(instruction);
      regs[0]  = cur.rs1;
      regs[1]  = cur.rs2;
      regs[2]  = cur.rd;
      hz = 0;
      foreach (regs[k]) begin
        if (regs[k] != 0) begin
          if (mdl_pend[regs[k]]) hz = 1;
          if (held_now && exp_q[0].rwe && exp_q[0].rd == regs[k]) hz = 1;
        end
      end
      exp_rdy   = !flush && !hz && (!held_now || out_ready);
      exp_stall = in_valid && hz && !flush;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("stall", 32'(stall), 32'(exp_stall));
      if (exp_stall && mdl_cnt < 65535) mdl_cnt++;
      issue_now = held_now && out_ready && !flush;
      drop_now  = held_now && flush;
      if (in_valid && exp_rdy) exp_q.push_back(cur);
    end
  end

  // Monitor: compares the presented bundle with the head of the expected queue.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      chk("out_valid", 32'(out_valid), 32'(held_now));
      if (held_now && exp_q.size() > 0) begin
        chk("op_select", 32'(op_select), 32'(exp_q[0].op));
        chk("reg_write_addr", 32'(reg_write_addr), 32'(exp_q[0].rd));
        chk("reg_read_addr1", 32'(reg_read_addr1), 32'(exp_q[0].rs1));
        chk("reg_read_addr2", 32'(reg_read_addr2), 32'(exp_q[0].rs2));
        chk("imm", 32'(imm), 32'(exp_q[0].imm));
        chk("mem_write", 32'(mem_write), 32'(exp_q[0].mem));
        chk("reg_write_enable", 32'(reg_write_enable), 32'(exp_q[0].rwe));
        if (issue_now) begin
          if (exp_q[0].rwe) mdl_pend[exp_q[0].rd] = 1'b1;
          void'(exp_q.pop_front());
        end else if (drop_now) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic iv, input logic [23:0] ins, input logic fl, input logic ordy,
                       input logic wbv, input logic [3:0] wba, output logic rdy_s, output logic stl_s);
    in_valid    = iv;
    instruction = ins;
    flush       = fl;
    out_ready   = ordy;
    wb_valid    = wbv;
    wb_addr     = wba;
    #1;
    rdy_s = in_ready;
    stl_s = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_op_select", 32'(op_select), 0);
    chk("rst_rd", 32'(reg_write_addr), 0);
    chk("rst_rs1", 32'(reg_read_addr1), 0);
    chk("rst_rs2", 32'(reg_read_addr2), 0);
    chk("rst_imm", 32'(imm), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_rwe", 32'(reg_write_enable), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_stall_count", 32'(stall_count), 0);
  endtask

  initial begin
    logic r, s;
    logic [23:0] x;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset();

    // Basic decode, negative immediate, register write.
    drive(1, mk(3, 1, 2, 3, 'h7F, 0), 0, 0, 0, 0, r, s);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_imm", 32'(imm), 32'hFFFF);
    chk("t1_rwe", 32'(reg_write_enable), 1);
    chk("t1_mem", 32'(mem_write), 0);
    drive(0, 0, 0, 1, 0, 0, r, s);
    chk("t1_pending1", 32'(pending[1]), 1);

    // Memory-write mode; writeback bypass of the r1 hazard.
    drive(1, mk(3, 1, 2, 3, 'h7F, 1), 0, 0, 1, 1, r, s);
    chk("t2_bypass_rdy", 32'(r), 1);
    chk("t2_mem", 32'(mem_write), 1);
    chk("t2_rwe", 32'(reg_write_enable), 0);
    drive(0, 0, 0, 1, 0, 0, r, s);
    chk("t2_pending", 32'(pending), 0);

    // RAW hazard on r5, then release by writeback.
    drive(1, mk(2, 5, 0, 0, 0, 0), 0, 1, 0, 0, r, s);
    for (int i = 0; i < 3; i++) begin
      drive(1, mk(4, 7, 5, 0, 0, 0), 0, 1, 0, 0, r, s);
      chk("t3_stall_rdy", 32'(r), 0);
      chk("t3_stall", 32'(s), 1);
    end
    chk("t3_stall_count", 32'(stall_count), 3);
    drive(1, mk(4, 7, 5, 0, 0, 0), 0, 1, 1, 5, r, s);
    chk("t3_wb_rdy", 32'(r), 1);
    chk("t3_rs1", 32'(reg_read_addr1), 5);
    chk("t3_pending5", 32'(pending[5]), 0);

    // Register 0 is never pending and never stalls.
    drive(0, 0, 0, 1, 0, 0, r, s);
    drive(1, mk(1, 0, 0, 0, 0, 0), 0, 1, 0, 0, r, s);
    chk("t4_rwe0", 32'(reg_write_enable), 0);
    drive(1, mk(1, 0, 0, 0, 5, 0), 0, 1, 0, 0, r, s);
    chk("t4_r0_rdy", 32'(r), 1);
    chk("t4_pending0", 32'(pending[0]), 0);
    chk("t4_imm", 32'(imm), 5);

    // Back-pressure hold, then flush.
    drive(1, mk(6, 8, 9, 10, 'h15, 0), 0, 1, 0, 0, r, s);
    for (int i = 0; i < 4; i++) begin
      drive(1, mk(9, 11, 12, 13, 0, 0), 0, 0, 0, 0, r, s);
      chk("t5_hold_rdy", 32'(r), 0);
      chk("t5_hold_op", 32'(op_select), 6);
      chk("t5_hold_imm", 32'(imm), 'h15);
    end
    drive(1, mk(9, 11, 12, 13, 0, 0), 1, 1, 0, 0, r, s);
    chk("t5_flush_valid", 32'(out_valid), 0);
    chk("t5_flush_pending", 32'(pending), 32'h0080);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      int cand[$];
      logic [3:0] wa;
      for (int k = 0; k < 16; k++) if (mdl_pend[k]) cand.push_back(k);
      if (cand.size() > 0 && $urandom_range(3) != 0) wa = 4'(cand[$urandom_range(cand.size() - 1)]);
      else wa = 4'($urandom_range(15));
      x = 24'($urandom);
      drive($urandom_range(3) != 0, x, $urandom_range(19) == 0, $urandom_range(3) != 0,
            $urandom_range(1) == 1, wa, r, s);
    end

    // Counter saturation under a sustained hazard.
    do_reset();
    check_reset();
    drive(1, mk(2, 9, 0, 0, 0, 0), 0, 1, 0, 0, r, s);
    for (int i = 0; i < 70000; i++) drive(1, mk(4, 3, 9, 0, 0, 0), 0, 1, 0, 0, r, s);
    chk("t6_saturated", 32'(stall_count), 32'hFFFF);
    do_reset();
    check_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_instruction_decoder.md
Name: pipelined_instruction_decoder

Overview:
- Registered, parametrised instruction decode stage between fetch and execute.
- Splits an INSTR_W-bit word into opcode, destination, two sources, immediate and mode, and holds the result in one output register under valid/ready handshakes.
- Separates memory-write from register-write via a mode bit.
- Keeps a per-register pending-write scoreboard and stalls fetch on RAW/WAW hazards until writeback clears them.

Parameters:
- INSTR_W, 24, instruction width in bits.
- OPC_W, 4, opcode field width.
- REG_AW, 4, register address width; NUM_REGS = 2**REG_AW (derived localparam).
- DATA_W, 16, width of the sign-extended immediate output.
- ZERO_REG_EN, 1, when 1 register 0 is hardwired: never marked pending, never causes a stall.
- Derived IMM_W = INSTR_W-OPC_W-3*REG_AW-1; elaboration error if IMM_W < 1 or IMM_W > DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  decoder accepts this cycle
- instruction  in  INSTR_W  raw instruction word
- flush  in  1  squash held output, no accept this cycle
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes bundle
- op_select  out  OPC_W  opcode
- reg_write_addr  out  REG_AW  rd
- reg_read_addr1  out  REG_AW  rs1
- reg_read_addr2  out  REG_AW  rs2
- imm  out  DATA_W  sign-extended immediate
- mem_write  out  1  mode=1
- reg_write_enable  out  1  mode=0 and not (ZERO_REG_EN and rd==0)
- wb_valid  in  1  writeback completing
- wb_addr  in  REG_AW  register written back
- stall  out  1  in_valid high but blocked by hazard
- pending  out  NUM_REGS  scoreboard state, debug
- stall_count  out  16  saturating hazard-stall cycle counter

Behaviour:
- Field map, MSB first: opcode [INSTR_W-1 -: OPC_W], rd, rs1, rs2 (REG_AW each), imm (IMM_W), mode bit [0].
- imm is sign-extended from bit IMM_W-1 of its field.
- Reset (sync): out_valid=0, all decoded fields 0, pending=0, stall_count=0.
- Accept is defined as in_valid && in_ready.
  - in_ready = !flush && !hazard && (!out_valid || out_ready).
  - On accept, all outputs are registered the next cycle. Latency is 1 cycle.
- Output hold: while out_valid && !out_ready, all outputs stay stable.
- Hazard (combinational): any of rs1, rs2 or rd of the incoming word matches a register that is busy.
  - A register is busy when its pending bit is set after this cycle's writeback clear, or it is the rd of a held bundle with reg_write_enable=1.
  - Register 0 is excluded when ZERO_REG_EN=1.
- Scoreboard:
  - Set: a bit is set when a bundle issues (out_valid && out_ready && reg_write_enable).
  - Clear: wb_valid clears bit wb_addr.
  - Same address set and cleared in one cycle: set wins.
  - A wb_valid to a non-pending register is ignored.
- Writeback bypass: wb_valid clearing a bit in the same cycle removes the hazard that cycle, so no extra stall.
- Flush:
  - Next cycle out_valid=0.
  - The held bundle is discarded and never sets pending.
  - The scoreboard is unchanged.
  - Flush beats a simultaneous issue: out_ready is ignored that cycle.
- stall = in_valid && hazard && !flush.
  - stall_count increments each stall cycle and saturates at 0xFFFF.
- Back-to-back throughput: 1 instruction/cycle with no hazards and out_ready held high.

Decomposition:
- Package decoder_pkg:
  - Field offset/width localparam functions of INSTR_W/OPC_W/REG_AW.
  - Sign-extend function.
  - Mode encoding constants MODE_REG=0, MODE_MEM=1.
- Sub-module reg_scoreboard, parameters REG_AW and ZERO_REG_EN.
  - Inputs: set_en, set_addr, clr_en, clr_addr, query addresses.
  - Outputs: pending vector and per-query busy flags.
- The top module holds the output register, handshake, flush and counter.

Test Plan:
- Reset, then instruction 0x3_1_2_3_7F_0 (op=3, rd=1, rs1=2, rs2=3, imm=0x7F, mode 0) -> next cycle out_valid=1, imm=0xFFFF, reg_write_enable=1, mem_write=0; on issue pending[1]=1.
- Same fields with mode=1 -> mem_write=1, reg_write_enable=0, pending unchanged.
- Issue write to r5, then an instruction reading r5 -> in_ready=0, stall=1, stall_count counts.
  - Assert wb_valid, wb_addr=5 -> accepted the same cycle, pending[5]=0.
- Write to r0 with ZERO_REG_EN=1 -> reg_write_enable=0, pending[0] stays 0, a following r0 read does not stall.
- out_ready low for 4 cycles with in_valid high -> outputs stable, in_ready=0.
  - Then flush -> out_valid=0 next cycle, pending unchanged.
- Hold a hazard 70000 cycles -> stall_count=0xFFFF.
  - Then rst for one cycle -> all outputs and pending return to 0.
